fd_stage: RTL and testbench
===========================

FD_STAGE -- requirements
Module: fd_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the fetched-instruction counter.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports in_code, in_fun, ra, rb, input, 4 each: fields decoded by fetch this cycle.
REQ-005 SHALL have ports val_c, val_p, input, 64 each: fetch constant word and fall-through PC.
REQ-006 SHALL have ports in_error, bad_mem, flag_halt, input, 1 each: fetch status flags.
REQ-007 SHALL have ports f_stall, d_stall, d_bubble, input, 1 each: hazard-control requests.
REQ-008 SHALL have ports m_icode, input, 4; m_cnd, input, 1; m_vala, input, 64: memory-stage feedback.
REQ-009 SHALL have ports w_icode, input, 4; w_valm, input, 64: writeback-stage feedback.
REQ-010 SHALL have port f_pc, output, 64: selected PC driven to fetch.
REQ-011 SHALL have port pred_pc, output, 64: registered predicted PC.
REQ-012 SHALL have ports d_code, d_fun, d_ra, d_rb (4 each), d_valc, d_valp (64 each), d_stat (4): registered decode-stage fields.
REQ-013 SHALL have port frozen, output, 1: fetch frozen after a non-AOK instruction.
REQ-014 SHALL have port fetch_cnt, output, CNT_W: count of real instructions loaded into D.

Function
REQ-015 SHALL encode status as AOK=4'b1000, HLT=4'b0010, ADR=4'b0001, INS=4'b0100.
REQ-016 SHALL form fetch status combinationally with priority bad_mem -> ADR, in_error -> INS, flag_halt -> HLT, else AOK.
REQ-017 SHALL drive f_pc combinationally: m_icode==4'h7 and !m_cnd -> m_vala; else w_icode==4'h9 -> w_valm; else pred_pc.
REQ-018 SHALL compute next prediction as val_c when in_code is 4'h7 (jXX) or 4'h8 (call), else val_p.
REQ-019 SHALL load pred_pc with next prediction each cycle unless f_stall or frozen is high, in which case it holds.
REQ-020 SHALL update the D register with priority: d_stall -> hold all fields; else d_bubble -> insert bubble; else frozen -> insert bubble; else load the fetched fields and status.
REQ-021 SHALL define a bubble as d_code=4'h1 (nop), d_fun=0, d_ra=d_rb=4'hF, d_valc=d_valp=0, d_stat=AOK.
REQ-022 SHALL set frozen on the edge at which a non-AOK status is loaded into D.
REQ-023 SHALL clear frozen on any edge with m_icode==4'h7 and !m_cnd (wrong-path squash), taking precedence over a same-cycle set.
REQ-024 SHALL increment fetch_cnt by one on each edge that loads fetched fields into D, saturating at all-ones.
REQ-025 SHALL have a latency of one cycle from fetch fields to D outputs; f_pc has zero-cycle latency.

Reset
REQ-026 SHALL, on reset, set pred_pc=0, frozen=0, fetch_cnt=0 and load a bubble into D, overriding all stall/bubble inputs.
REQ-027 SHALL, on reset asserted mid-operation, discard the in-flight D contents in the same edge; the first post-reset f_pc is 0 absent feedback redirects.

Structure
REQ-028 SHALL take status encodings, opcode constants (HALT, NOP, JXX, CALL, RET) and the REG_NONE value from a shared y86 constants package.
REQ-029 SHALL contain one sub-module, fd_pred, computing the next-PC prediction; selection, register and counter logic stay in fd_stage.

Verification
REQ-030 SHALL cover: reset, then irmovq (in_code=3, val_p=10) -> next cycle d_code=3, d_valp=10, pred_pc=10, fetch_cnt=1.
REQ-031 SHALL cover: jXX with val_c=0x40 -> pred_pc=0x40; later m_icode=7, m_cnd=0, m_vala=0x22 -> f_pc=0x22 that cycle.
REQ-032 SHALL cover: w_icode=9, w_valm=0x80 with no mispredict -> f_pc=0x80; with simultaneous mispredict -> f_pc=m_vala.
REQ-033 SHALL cover: d_stall and d_bubble both high -> D unchanged, fetch_cnt unchanged; d_bubble alone -> d_code=1, d_stat=AOK.
REQ-034 SHALL cover: flag_halt loaded -> d_stat=HLT, frozen=1, pred_pc held, subsequent D bubbles; mispredict -> frozen=0 next edge.
REQ-035 SHALL cover: fetch_cnt preloaded near all-ones (CNT_W=4) -> saturates at 4'hF; reset mid-stream -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/fd_stage_pkg.sv
// Shared y86 constants: status codes, opcodes, register id, D-register layout.
// Pure declarations; no logic, no latency, no stall behaviour.
package fd_stage_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0001;
    localparam logic [3:0] STAT_INS = 4'b0100;

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]  code;
        logic [3:0]  fun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [3:0]  stat;
    } dreg_t;

    localparam dreg_t D_BUBBLE = '{code: I_NOP, fun: 4'h0, ra: REG_NONE, rb: REG_NONE,
                                   valc: 64'h0, valp: 64'h0, stat: STAT_AOK};

endpackage

// File: rtl/fd_stage_if.sv
// Fetch/decode boundary bundle: fetch fields, hazard controls, M/W feedback, D outputs.
// Master is the surrounding pipeline; slave is the fd_stage block.
interface fd_stage_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       in_code;
    logic [3:0]       in_fun;
    logic [3:0]       ra;
    logic [3:0]       rb;
    logic [63:0]      val_c;
    logic [63:0]      val_p;
    logic             in_error;
    logic             bad_mem;
    logic             flag_halt;
    logic             f_stall;
    logic             d_stall;
    logic             d_bubble;
    logic [3:0]       m_icode;
    logic             m_cnd;
    logic [63:0]      m_vala;
    logic [3:0]       w_icode;
    logic [63:0]      w_valm;
    logic [63:0]      f_pc;
    logic [63:0]      pred_pc;
    logic [3:0]       d_code;
    logic [3:0]       d_fun;
    logic [3:0]       d_ra;
    logic [3:0]       d_rb;
    logic [63:0]      d_valc;
    logic [63:0]      d_valp;
    logic [3:0]       d_stat;
    logic             frozen;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output in_code, in_fun, ra, rb, val_c, val_p, in_error, bad_mem, flag_halt,
               f_stall, d_stall, d_bubble, m_icode, m_cnd, m_vala, w_icode, w_valm,
        input  f_pc, pred_pc, d_code, d_fun, d_ra, d_rb, d_valc, d_valp, d_stat,
               frozen, fetch_cnt
    );

    modport slave (
        input  in_code, in_fun, ra, rb, val_c, val_p, in_error, bad_mem, flag_halt,
               f_stall, d_stall, d_bubble, m_icode, m_cnd, m_vala, w_icode, w_valm,
        output f_pc, pred_pc, d_code, d_fun, d_ra, d_rb, d_valc, d_valp, d_stat,
               frozen, fetch_cnt
    );

endinterface

// File: rtl/fd_pred.sv
// Next-PC predictor: taken for jumps and calls, fall-through otherwise.
// Combinational, zero latency, no stall handling of its own.
module fd_pred
    import fd_stage_pkg::*;
(
    input  logic [3:0]  in_code_i,
    input  logic [63:0] val_c_i,
    input  logic [63:0] val_p_i,
    output logic [63:0] pred_next_o
);

    always_comb begin
        pred_next_o = val_p_i;
        if (in_code_i == I_JXX || in_code_i == I_CALL) begin
            pred_next_o = val_c_i;
        end
    end

endmodule

// File: rtl/fd_stage.sv
// Fetch PC selection, predicted-PC register and F->D pipeline register.
// f_pc is combinational; D outputs one cycle after fetch; d_stall holds, d_bubble/frozen inject nops.
module fd_stage
    import fd_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic          clock,
    input logic          reset,
    fd_stage_if.slave    bus
);

    logic [63:0]      pred_next;
    logic [63:0]      pred_pc_q, pred_pc_d;
    dreg_t            dreg_q, dreg_d, fetched;
    logic             frozen_q, frozen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       f_stat;
    logic             mispredict;
    logic             load_d;

    fd_pred u_pred (
        .in_code_i   (bus.in_code),
        .val_c_i     (bus.val_c),
        .val_p_i     (bus.val_p),
        .pred_next_o (pred_next)
    );

    always_comb begin
        if (bus.bad_mem)        f_stat = STAT_ADR;
        else if (bus.in_error)  f_stat = STAT_INS;
        else if (bus.flag_halt) f_stat = STAT_HLT;
        else                    f_stat = STAT_AOK;

        mispredict = (bus.m_icode == I_JXX) && !bus.m_cnd;
        load_d     = !bus.d_stall && !bus.d_bubble && !frozen_q;

        if (mispredict)                 bus.f_pc = bus.m_vala;
        else if (bus.w_icode == I_RET)  bus.f_pc = bus.w_valm;
        else                            bus.f_pc = pred_pc_q;

        fetched = '{code: bus.in_code, fun: bus.in_fun, ra: bus.ra, rb: bus.rb,
                    valc: bus.val_c, valp: bus.val_p, stat: f_stat};

        pred_pc_d = (bus.f_stall || frozen_q) ? pred_pc_q : pred_next;

        dreg_d = dreg_q;
        if (!bus.d_stall) begin
            dreg_d = load_d ? fetched : D_BUBBLE;
        end

        // A wrong-path squash wins over a faulting instruction arriving the same cycle.
        frozen_d = frozen_q;
        if (mispredict)                           frozen_d = 1'b0;
        else if (load_d && f_stat != STAT_AOK)    frozen_d = 1'b1;

        cnt_d = cnt_q;
        if (load_d && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_pc_q <= 64'h0;
            dreg_q    <= D_BUBBLE;
            frozen_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pred_pc_q <= pred_pc_d;
            dreg_q    <= dreg_d;
            frozen_q  <= frozen_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pred_pc   = pred_pc_q;
    assign bus.d_code    = dreg_q.code;
    assign bus.d_fun     = dreg_q.fun;
    assign bus.d_ra      = dreg_q.ra;
    assign bus.d_rb      = dreg_q.rb;
    assign bus.d_valc    = dreg_q.valc;
    assign bus.d_valp    = dreg_q.valp;
    assign bus.d_stat    = dreg_q.stat;
    assign bus.frozen    = frozen_q;
    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fd_stage.sv
// Directed scoreboard bench for fd_stage with a 4-bit fetch counter.
module tb_fd_stage;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0010;
    localparam logic [3:0] ADR = 4'b0001;
    localparam logic [3:0] INS = 4'b0100;

    localparam logic [4:0] M_FPC = 5'b00001;
    localparam logic [4:0] M_PPC = 5'b00010;
    localparam logic [4:0] M_D   = 5'b00100;
    localparam logic [4:0] M_FRZ = 5'b01000;
    localparam logic [4:0] M_CNT = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct packed {
        logic [95:0] name;
        logic [4:0]  mask;
        logic [63:0] f_pc;
        logic [63:0] pred_pc;
        logic [3:0]  code;
        logic [3:0]  fun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [3:0]  stat;
        logic        frozen;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t e;
    exp_t sbq[$];

    always #5 clk = ~clk;

    fd_stage_if #(.CNT_W(4)) bus ();

    fd_stage #(.CNT_W(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input logic [95:0] nm, input string fld,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s.%0s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every registered update is compared against the oldest pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                if (x.mask & M_FPC) chk(x.name, "f_pc", bus.f_pc, x.f_pc);
                if (x.mask & M_PPC) chk(x.name, "pred_pc", bus.pred_pc, x.pred_pc);
                if (x.mask & M_D) begin
                    chk(x.name, "d_code", {60'h0, bus.d_code}, {60'h0, x.code});
                    chk(x.name, "d_fun",  {60'h0, bus.d_fun},  {60'h0, x.fun});
                    chk(x.name, "d_ra",   {60'h0, bus.d_ra},   {60'h0, x.ra});
                    chk(x.name, "d_rb",   {60'h0, bus.d_rb},   {60'h0, x.rb});
                    chk(x.name, "d_valc", bus.d_valc, x.valc);
                    chk(x.name, "d_valp", bus.d_valp, x.valp);
                    chk(x.name, "d_stat", {60'h0, bus.d_stat}, {60'h0, x.stat});
                end
                if (x.mask & M_FRZ) chk(x.name, "frozen", {63'h0, bus.frozen}, {63'h0, x.frozen});
                if (x.mask & M_CNT) chk(x.name, "fetch_cnt", {60'h0, bus.fetch_cnt}, {60'h0, x.cnt});
            end
        end
    end

    task automatic fetch(input logic [3:0] code, input logic [3:0] fun, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        bus.in_code = code; bus.in_fun = fun; bus.ra = ra; bus.rb = rb;
        bus.val_c = vc; bus.val_p = vp;
    endtask

    task automatic exp_d(input logic [3:0] code, input logic [3:0] fun, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [3:0] stat);
        e.code = code; e.fun = fun; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.stat = stat;
    endtask

    task automatic exp_bubble();
        exp_d(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, AOK);
    endtask

    task automatic issue(input logic [95:0] nm, input logic [4:0] mk);
        e.name = nm;
        e.mask = mk;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        e = '0;
        fetch(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
        bus.in_error = 0; bus.bad_mem = 0; bus.flag_halt = 0;
        bus.f_stall = 0; bus.d_stall = 0; bus.d_bubble = 0;
        bus.m_icode = 0; bus.m_cnd = 0; bus.m_vala = 0;
        bus.w_icode = 0; bus.w_valm = 0;
        @(negedge clk);
        @(negedge clk);

        e.f_pc = 0; e.pred_pc = 0; exp_bubble(); e.frozen = 0; e.cnt = 0;
        issue("reset", M_ALL);
        rst = 0;

        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10);
        e.pred_pc = 64'd10; e.f_pc = 64'd10; e.cnt = 1;
        exp_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10, AOK);
        issue("irmovq", M_ALL);

        fetch(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h13);
        e.pred_pc = 64'h40; e.f_pc = 64'h40; e.cnt = 2;
        exp_d(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h13, AOK);
        issue("jxx", M_ALL);

        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41);
        bus.m_icode = 4'h7; bus.m_cnd = 0; bus.m_vala = 64'h22;
        e.pred_pc = 64'h41; e.f_pc = 64'h22; e.cnt = 3;
        exp_d(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, AOK);
        issue("mispred", M_ALL);

        bus.m_icode = 4'h0;
        bus.w_icode = 4'h9; bus.w_valm = 64'h80;
        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h42);
        e.pred_pc = 64'h42; e.f_pc = 64'h80; e.cnt = 4; e.valp = 64'h42;
        issue("ret", M_ALL);

        bus.m_icode = 4'h7; bus.m_cnd = 0; bus.m_vala = 64'h22;
        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h43);
        e.pred_pc = 64'h43; e.f_pc = 64'h22; e.cnt = 5; e.valp = 64'h43;
        issue("ret_mispr", M_ALL);

        bus.m_icode = 0; bus.w_icode = 0;
        bus.d_stall = 1; bus.d_bubble = 1;
        fetch(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h50);
        e.pred_pc = 64'h50; e.f_pc = 64'h50;
        issue("stall_bub", M_ALL);

        bus.d_stall = 0; bus.f_stall = 1;
        fetch(4'h7, 4'h0, 4'hF, 4'hF, 64'h99, 64'h59);
        exp_bubble();
        issue("bubble", M_ALL);

        bus.d_bubble = 0; bus.f_stall = 0; bus.flag_halt = 1;
        fetch(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51);
        e.pred_pc = 64'h51; e.f_pc = 64'h51; e.frozen = 1; e.cnt = 6;
        exp_d(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, HLT);
        issue("halt", M_ALL);

        bus.flag_halt = 0;
        fetch(4'h3, 4'h0, 4'hF, 4'h1, 64'h0, 64'h60);
        exp_bubble();
        issue("frozen", M_ALL);

        bus.m_icode = 4'h7; bus.m_cnd = 0; bus.m_vala = 64'h30;
        fetch(4'h3, 4'h0, 4'hF, 4'h1, 64'h0, 64'h61);
        e.f_pc = 64'h30; e.frozen = 0;
        issue("unfreeze", M_ALL);

        bus.m_icode = 0;
        bus.bad_mem = 1; bus.in_error = 1; bus.flag_halt = 1;
        fetch(4'h3, 4'h0, 4'hF, 4'h3, 64'h7, 64'h62);
        e.pred_pc = 64'h62; e.f_pc = 64'h62; e.frozen = 1; e.cnt = 7;
        exp_d(4'h3, 4'h0, 4'hF, 4'h3, 64'h7, 64'h62, ADR);
        issue("adr_prio", M_ALL);

        bus.bad_mem = 0; bus.flag_halt = 0;
        bus.m_icode = 4'h7; bus.m_cnd = 0; bus.m_vala = 64'h70;
        e.f_pc = 64'h70; e.frozen = 0;
        exp_bubble();
        issue("squash", M_ALL);

        fetch(4'h3, 4'h0, 4'hF, 4'h3, 64'h7, 64'h63);
        e.pred_pc = 64'h63; e.cnt = 8;
        exp_d(4'h3, 4'h0, 4'hF, 4'h3, 64'h7, 64'h63, INS);
        issue("clr_wins", M_ALL);

        bus.m_cnd = 1; bus.in_error = 0;
        fetch(4'h2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h64);
        e.pred_pc = 64'h64; e.f_pc = 64'h64; e.cnt = 9;
        exp_d(4'h2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h64, AOK);
        issue("jtaken", M_ALL);

        bus.m_icode = 0;
        for (int i = 0; i < 8; i++) begin
            fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h70 + 64'(i));
            e.pred_pc = 64'h70 + 64'(i); e.f_pc = e.pred_pc;
            e.cnt = (10 + i > 15) ? 4'hF : 4'(10 + i);
            issue("cnt_sat", M_PPC | M_FPC | M_CNT);
        end

        rst = 1;
        bus.d_stall = 1; bus.d_bubble = 1; bus.f_stall = 1;
        fetch(4'h7, 4'h0, 4'h1, 4'h1, 64'h55, 64'h56);
        e.f_pc = 0; e.pred_pc = 0; exp_bubble(); e.frozen = 0; e.cnt = 0;
        issue("rst_mid", M_ALL);

        rst = 0;
        bus.d_stall = 0; bus.d_bubble = 0; bus.f_stall = 0;
        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10);
        e.pred_pc = 64'd10; e.f_pc = 64'd10; e.cnt = 1;
        exp_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h5, 64'd10, AOK);
        issue("post_rst", M_ALL);

        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
